pipeline_flush_unit: RTL and testbench

PIPELINE_FLUSH_UNIT -- requirements
Module: pipeline_flush_unit

---
 rtl/risc_v_pkg.sv | 26 ++
 rtl/flush_counter.sv | 33 +++
 rtl/pipeline_flush_unit.sv | 124 ++++++++++++
 tb/tb_pipeline_flush_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/risc_v_pkg.sv
// Shared definitions for the pipeline control blocks.
//   - flush_state_t : flush FSM states (IDLE / REDIRECT / DRAIN)
//   - flush_src_t   : origin of the current redirect (BRANCH / JUMP)
//   - CNT_W         : width of the bubble counter
//   - JAL_INS / JALR_INS : RV32I opcodes of the decode-stage jumps
package risc_v_pkg;

    localparam int CNT_W = 3;

    localparam logic [6:0] JAL_INS  = 7'b1101111;
    localparam logic [6:0] JALR_INS = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } flush_state_t;

    // BRANCH is encoded as 0 so that the reset value of the source
    // register is a legal enum member.
    typedef enum logic {
        SRC_BRANCH = 1'b0,
        SRC_JUMP   = 1'b1
    } flush_src_t;

endpackage

// File: rtl/flush_counter.sv
// Loadable bubble down-counter with hold-on-stall.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : load load_value (wins over counting)
//   load_value  : number of flush cycles for a new redirect
//   run         : FSM is outside IDLE, counting is allowed
//   stall       : pipeline frozen, counter holds
//   count       : current remaining flush cycles (0 in IDLE)
module flush_counter
    import risc_v_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             run,
    input  logic             stall,
    output logic [CNT_W-1:0] count
);

    // The FSM leaves REDIRECT/DRAIN on the same edge that takes the count
    // from 1 to 0, so the counter reads 0 in IDLE and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (run && !stall && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_flush_unit.sv
// Pipeline flush / PC redirect controller.
// Captures a decode-stage jump (nop_inject) or an execute-stage taken branch,
// presents the registered redirect target to the PC mux for one (non-stalled)
// cycle, and keeps flushing IF/ID for the configured number of bubbles.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   nop_inject      : decode stage holds JAL/JALR
//   jump_target     : jump target from decode
//   branch_taken    : execute stage resolved a taken branch
//   branch_target   : branch target from execute
//   stall           : pipeline hazard stall (frozen cycle)
//   redirect_valid  : PC mux selects redirect_target
//   redirect_target : registered redirect PC
//   flush_if_id     : IF/ID register loads a NOP
//   flush_id_ex     : ID/EX register loads a NOP (branch redirects only)
//   busy            : FSM is not in IDLE
module pipeline_flush_unit
    import risc_v_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int JUMP_BUBBLES   = 1,
    parameter int BRANCH_BUBBLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            nop_inject,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_target,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            busy
);

    localparam logic [CNT_W-1:0] JUMP_CNT   = CNT_W'(JUMP_BUBBLES);
    localparam logic [CNT_W-1:0] BRANCH_CNT = CNT_W'(BRANCH_BUBBLES);

    flush_state_t     state;
    flush_state_t     state_next;
    flush_src_t       src;
    flush_src_t       src_next;
    logic [XLEN-1:0]  target_next;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic [CNT_W-1:0] count;

    flush_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (load_value),
        .run        (state != IDLE),
        .stall      (stall),
        .count      (count)
    );

    // Next-state decision. A branch is the older instruction, so it wins
    // over a simultaneous jump and may preempt a jump redirect in flight;
    // anything arriving from decode while a redirect is active is wrong-path.
    always_comb begin
        state_next  = state;
        src_next    = src;
        target_next = redirect_target;
        load        = 1'b0;
        load_value  = '0;
        case (state)
            IDLE: begin
                if (branch_taken) begin
                    state_next  = REDIRECT;
                    src_next    = SRC_BRANCH;
                    target_next = branch_target;
                    load        = 1'b1;
                    load_value  = BRANCH_CNT;
                end else if (nop_inject) begin
                    state_next  = REDIRECT;
                    src_next    = SRC_JUMP;
                    target_next = jump_target;
                    load        = 1'b1;
                    load_value  = JUMP_CNT;
                end
            end
            REDIRECT, DRAIN: begin
                if (branch_taken && (src == SRC_JUMP)) begin
                    state_next  = REDIRECT;
                    src_next    = SRC_BRANCH;
                    target_next = branch_target;
                    load        = 1'b1;
                    load_value  = BRANCH_CNT;
                end else if (!stall) begin
                    state_next = (count == CNT_W'(1)) ? IDLE : DRAIN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register one cycle after capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            src             <= SRC_BRANCH;
            redirect_target <= '0;
            redirect_valid  <= 1'b0;
            flush_if_id     <= 1'b0;
            flush_id_ex     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_next;
            src             <= src_next;
            redirect_target <= target_next;
            redirect_valid  <= (state_next == REDIRECT);
            flush_if_id     <= (state_next != IDLE);
            flush_id_ex     <= (state_next == REDIRECT) && (src_next == SRC_BRANCH);
            busy            <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_pipeline_flush_unit.sv
// Bench for pipeline_flush_unit: directed scenarios followed by random
// traffic, checked against a schedule-based reference model.
module tb_pipeline_flush_unit;

    localparam int XLEN = 32;
    localparam int JB   = 1;
    localparam int BB   = 2;
    localparam int W    = XLEN + 4;

    logic            clk;
    logic            rst;
    logic            nop_inject;
    logic [XLEN-1:0] jump_target;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // expected {busy, redirect_valid, flush_if_id, flush_id_ex, redirect_target}
    logic [W-1:0] exp_q[$];

    pipeline_flush_unit #(
        .XLEN           (XLEN),
        .JUMP_BUBBLES   (JB),
        .BRANCH_BUBBLES (BB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .nop_inject      (nop_inject),
        .jump_target     (jump_target),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .busy            (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A redirect is a schedule of flush cycles: the first one steers the PC
    // (and kills ID/EX for a branch), the rest only kill IF/ID. Each
    // non-stalled cycle consumes one slot; a stall keeps the current slot.
    typedef struct packed {
        logic rv;
        logic fex;
    } slot_t;

    slot_t           sched[$];
    logic [XLEN-1:0] m_tgt;
    bit              m_branch;

    task automatic model_capture(input bit is_branch, input logic [XLEN-1:0] t);
        int n;
        n = is_branch ? BB : JB;
        sched.delete();
        sched.push_back(slot_t'{rv: 1'b1, fex: is_branch});
        for (int i = 1; i < n; i++) sched.push_back(slot_t'{rv: 1'b0, fex: 1'b0});
        m_branch = is_branch;
        m_tgt    = t;
    endtask

    task automatic model_step(input bit r, input bit nop, input logic [XLEN-1:0] jt,
                              input bit bt, input logic [XLEN-1:0] btg, input bit st);
        logic [W-1:0] e;
        if (r) begin
            sched.delete();
            m_tgt    = '0;
            m_branch = 1'b1;
        end else if (sched.size() == 0) begin
            if (bt) model_capture(1'b1, btg);
            else if (nop) model_capture(1'b0, jt);
        end else begin
            if (bt && !m_branch) model_capture(1'b1, btg);
            else if (!st) void'(sched.pop_front());
        end
        if (sched.size() != 0) e = {1'b1, sched[0].rv, 1'b1, sched[0].fex, m_tgt};
        else                   e = {4'b0000, m_tgt};
        exp_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit r, input bit nop, input logic [XLEN-1:0] jt,
                         input bit bt, input logic [XLEN-1:0] btg, input bit st);
        @(posedge clk);
        #2;
        rst           = r;
        nop_inject    = nop;
        jump_target   = jt;
        branch_taken  = bt;
        branch_target = btg;
        stall         = st;
        model_step(r, nop, jt, bt, btg, st);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        #1;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {busy, redirect_valid, flush_if_id, flush_id_ex, redirect_target};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got busy=%b rv=%b fif=%b fex=%b tgt=%h expected busy=%b rv=%b fif=%b fex=%b tgt=%h",
                         $time, got[W-1], got[W-2], got[W-3], got[W-4], got[XLEN-1:0],
                         e[W-1], e[W-2], e[W-3], e[W-4], e[XLEN-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        nop_inject    = 1'b0;
        jump_target   = '0;
        branch_taken  = 1'b0;
        branch_target = '0;
        stall         = 1'b0;
        m_tgt         = '0;
        m_branch      = 1'b1;

        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(2);

        // jump
        drive(1'b0, 1'b1, 32'h40, 1'b0, '0, 1'b0);
        idle(3);
        // branch
        drive(1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b0);
        idle(4);
        // simultaneous jump and branch
        drive(1'b0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0);
        idle(4);
        // branch held by three stall cycles
        drive(1'b0, 1'b0, '0, 1'b1, 32'h300, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        idle(4);
        // jump captured under stall, preempted by branch, nop ignored in DRAIN
        drive(1'b0, 1'b1, 32'h40, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1, 32'h80, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b1, 32'h44, 1'b0, '0, 1'b0);
        idle(3);
        // reset during DRAIN
        drive(1'b0, 1'b0, '0, 1'b1, 32'h500, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b1, 32'h60, 1'b1, 32'h600, 1'b1);
        idle(3);
        // back-to-back requests right at the IDLE cycle
        drive(1'b0, 1'b1, 32'h70, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b1, 32'h74, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1, 32'h900, 1'b0);
        idle(4);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 4) == 0, $urandom,
                  $urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 3) == 0);
        end
        idle(4);

        @(posedge clk);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
